// File: rtl/ifu_pkg.sv
// Shared definitions for the instruction fetch unit: widths, state encodings and
// fixed constants also used by the PC register.
package ifu_pkg;

    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DATA_W = 32;

    localparam logic [DATA_W-1:0] NOP      = 32'h0000_0000;
    localparam logic [ADDR_W-1:0] RESET_PC = 32'h0000_0000;

    typedef enum logic [1:0] {
        IfIdle = 2'd0,
        IfWait = 2'd1,
        IfFull = 2'd2
    } if_state_e;

endpackage

// File: rtl/ifu_if.sv
// Bundle of PC, instruction-memory and decode-side signals around the fetch unit.
// The master modport is the fetch unit; the slave modport is its environment.
interface ifu_if #(
    parameter int unsigned ADDR_W = ifu_pkg::ADDR_W,
    parameter int unsigned DATA_W = ifu_pkg::DATA_W
) ();

    logic [ADDR_W-1:0] PC;
    logic              PCWr;
    logic              Flush;
    logic              IMemReq;
    logic [ADDR_W-1:0] IMemAddr;
    logic              IMemAck;
    logic [DATA_W-1:0] IMemData;
    logic              InstrValid;
    logic              InstrReady;
    logic [DATA_W-1:0] Instr;
    logic [ADDR_W-1:0] InstrPC;
    logic              FetchErr;

    modport master (
        input  PC, Flush, IMemAck, IMemData, InstrReady,
        output PCWr, IMemReq, IMemAddr, InstrValid, Instr, InstrPC, FetchErr
    );

    modport slave (
        output PC, Flush, IMemAck, IMemData, InstrReady,
        input  PCWr, IMemReq, IMemAddr, InstrValid, Instr, InstrPC, FetchErr
    );

endinterface

// File: rtl/ifu.sv
// Instruction fetch unit: issues one memory request per PC, holds the fetched word
// for decode under valid/ready, and enables the PC register on accept or redirect.
module ifu
    import ifu_pkg::*;
(
    input  logic  Clk,
    input  logic  Reset,
    ifu_if.master bus
);

    if_state_e         state_q, state_d;
    logic              drop_q, drop_d;
    logic              req_q, req_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] instr_q, instr_d;
    logic [ADDR_W-1:0] instr_pc_q, instr_pc_d;
    logic              err_q, err_d;

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_q    <= IfIdle;
            drop_q     <= 1'b0;
            req_q      <= 1'b0;
            addr_q     <= '0;
            instr_q    <= '0;
            instr_pc_q <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            drop_q     <= drop_d;
            req_q      <= req_d;
            addr_q     <= addr_d;
            instr_q    <= instr_d;
            instr_pc_q <= instr_pc_d;
            err_q      <= err_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        drop_d     = drop_q;
        req_d      = req_q;
        addr_d     = addr_q;
        instr_d    = instr_q;
        instr_pc_d = instr_pc_q;
        err_d      = err_q;

        unique case (state_q)
            IfIdle: begin
                if (bus.Flush) begin
                    state_d = IfIdle;
                end else if (bus.PC[1:0] != 2'b00) begin
                    // Misaligned PC never reaches memory; hand decode a tagged NOP.
                    state_d    = IfFull;
                    instr_d    = NOP;
                    instr_pc_d = bus.PC;
                    err_d      = 1'b1;
                end else begin
                    state_d = IfWait;
                    req_d   = 1'b1;
                    addr_d  = bus.PC;
                end
            end
            IfWait: begin
                if (bus.IMemAck) begin
                    req_d = 1'b0;
                    if (drop_q || bus.Flush) begin
                        drop_d  = 1'b0;
                        state_d = IfIdle;
                    end else begin
                        instr_d    = bus.IMemData;
                        instr_pc_d = addr_q;
                        err_d      = 1'b0;
                        state_d    = IfFull;
                    end
                end else if (bus.Flush) begin
                    // Finish the outstanding handshake, but remember to discard its data.
                    drop_d = 1'b1;
                end
            end
            IfFull: begin
                if (bus.InstrReady || bus.Flush) begin
                    state_d = IfIdle;
                end
            end
            default: begin
                state_d = IfIdle;
            end
        endcase
    end

    assign bus.InstrValid = (state_q == IfFull);
    assign bus.PCWr       = (bus.InstrValid & bus.InstrReady) | bus.Flush;
    assign bus.IMemReq    = req_q;
    assign bus.IMemAddr   = addr_q;
    assign bus.Instr      = instr_q;
    assign bus.InstrPC    = instr_pc_q;
    assign bus.FetchErr   = err_q;

endmodule

// File: tb/tb_ifu.sv
// Directed bench for the fetch unit: reset, zero-wait and multi-wait fetches,
// decode stall, flush during a fetch, misaligned PC and reset mid-fetch.
module tb_ifu;
    import ifu_pkg::*;

    logic Clk = 1'b0;
    logic Reset;
    int   n_checks = 0;
    int   n_fail   = 0;

    ifu_if bus ();

    ifu dut (
        .Clk   (Clk),
        .Reset (Reset),
        .bus   (bus)
    );

    always #5 Clk = ~Clk;

    task automatic test_reset();
        Reset          = 1'b0;
        bus.PC         = '0;
        bus.Flush      = 1'b0;
        bus.IMemAck    = 1'b0;
        bus.IMemData   = '0;
        bus.InstrReady = 1'b0;
        repeat (2) @(negedge Clk);
        n_checks++;
        if (bus.IMemReq !== 1'b0) begin
            n_fail++; $display("FAIL rst_req: got %b want 0", bus.IMemReq);
        end
        n_checks++;
        if (bus.InstrValid !== 1'b0 || bus.FetchErr !== 1'b0 || bus.PCWr !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_flags: valid=%b err=%b pcwr=%b want 0 0 0",
                     bus.InstrValid, bus.FetchErr, bus.PCWr);
        end
        n_checks++;
        if (bus.IMemAddr !== 32'h0 || bus.Instr !== 32'h0 || bus.InstrPC !== 32'h0) begin
            n_fail++;
            $display("FAIL rst_regs: addr=%h instr=%h ipc=%h want 0 0 0",
                     bus.IMemAddr, bus.Instr, bus.InstrPC);
        end
        Reset = 1'b1;
    endtask

    task automatic test_zero_wait();
        bus.PC         = 32'h0;
        bus.IMemAck    = 1'b1;
        bus.IMemData   = 32'h2008_0005;
        bus.InstrReady = 1'b1;
        @(negedge Clk);
        n_checks++;
        if (bus.IMemReq !== 1'b1 || bus.IMemAddr !== 32'h0 || bus.InstrValid !== 1'b0) begin
            n_fail++;
            $display("FAIL zw_issue: req=%b addr=%h valid=%b want 1 0 0",
                     bus.IMemReq, bus.IMemAddr, bus.InstrValid);
        end
        @(negedge Clk);
        n_checks++;
        if (bus.InstrValid !== 1'b1 || bus.Instr !== 32'h2008_0005 || bus.InstrPC !== 32'h0
            || bus.IMemReq !== 1'b0 || bus.FetchErr !== 1'b0) begin
            n_fail++;
            $display("FAIL zw_full: valid=%b instr=%h ipc=%h req=%b err=%b want 1 20080005 0 0 0",
                     bus.InstrValid, bus.Instr, bus.InstrPC, bus.IMemReq, bus.FetchErr);
        end
        n_checks++;
        if (bus.PCWr !== 1'b1) begin
            n_fail++; $display("FAIL zw_pcwr: got %b want 1", bus.PCWr);
        end
        bus.IMemAck = 1'b0;
        @(negedge Clk);
        n_checks++;
        if (bus.InstrValid !== 1'b0 || bus.PCWr !== 1'b0) begin
            n_fail++;
            $display("FAIL zw_accept: valid=%b pcwr=%b want 0 0", bus.InstrValid, bus.PCWr);
        end
    endtask

    task automatic test_wait4();
        int bad = 0;
        bus.PC         = 32'h10;
        bus.InstrReady = 1'b0;
        bus.IMemData   = 32'hDEAD_BEEF;
        for (int i = 0; i < 5; i++) begin
            @(negedge Clk);
            if (bus.IMemReq !== 1'b1 || bus.IMemAddr !== 32'h10 || bus.InstrValid !== 1'b0)
                bad++;
            if (i == 4) bus.IMemAck = 1'b1;
        end
        n_checks++;
        if (bad != 0) begin
            n_fail++; $display("FAIL w4_stable: %0d unstable cycles, want 0", bad);
        end
        @(negedge Clk);
        bus.IMemAck = 1'b0;
        n_checks++;
        if (bus.InstrValid !== 1'b1 || bus.Instr !== 32'hDEAD_BEEF || bus.InstrPC !== 32'h10
            || bus.IMemReq !== 1'b0) begin
            n_fail++;
            $display("FAIL w4_capture: valid=%b instr=%h ipc=%h req=%b want 1 deadbeef 10 0",
                     bus.InstrValid, bus.Instr, bus.InstrPC, bus.IMemReq);
        end
    endtask

    task automatic test_stall();
        int bad = 0;
        int pulses = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge Clk);
            if (bus.InstrValid !== 1'b1 || bus.Instr !== 32'hDEAD_BEEF
                || bus.InstrPC !== 32'h10 || bus.PCWr !== 1'b0)
                bad++;
        end
        n_checks++;
        if (bad != 0) begin
            n_fail++; $display("FAIL stall_hold: %0d bad cycles, want 0", bad);
        end
        bus.InstrReady = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            if (bus.PCWr === 1'b1) pulses++;
            @(negedge Clk);
        end
        n_checks++;
        if (pulses != 1) begin
            n_fail++; $display("FAIL stall_release: %0d PCWr pulses, want 1", pulses);
        end
        // Unit re-issued from PC 0x10 meanwhile; drain that fetch back to IDLE.
        bus.IMemAck = 1'b1;
        @(negedge Clk);
        bus.IMemAck = 1'b0;
        @(negedge Clk);
    endtask

    task automatic test_flush();
        int bad = 0;
        bus.InstrReady = 1'b0;
        bus.PC         = 32'h20;
        @(negedge Clk);
        n_checks++;
        if (bus.IMemReq !== 1'b1 || bus.IMemAddr !== 32'h20) begin
            n_fail++;
            $display("FAIL fl_issue: req=%b addr=%h want 1 20", bus.IMemReq, bus.IMemAddr);
        end
        @(negedge Clk);
        bus.Flush = 1'b1;
        bus.PC    = 32'h40;
        #1;
        n_checks++;
        if (bus.PCWr !== 1'b1) begin
            n_fail++; $display("FAIL fl_pcwr: got %b want 1", bus.PCWr);
        end
        @(negedge Clk);
        bus.Flush = 1'b0;
        n_checks++;
        if (bus.IMemReq !== 1'b1 || bus.IMemAddr !== 32'h20) begin
            n_fail++;
            $display("FAIL fl_hold: req=%b addr=%h want 1 20", bus.IMemReq, bus.IMemAddr);
        end
        @(negedge Clk);
        bus.IMemAck  = 1'b1;
        bus.IMemData = 32'h0BAD_0BAD;
        for (int i = 0; i < 2; i++) begin
            @(negedge Clk);
            bus.IMemAck = 1'b0;
            if (bus.InstrValid !== 1'b0) bad++;
        end
        n_checks++;
        if (bad != 0) begin
            n_fail++; $display("FAIL fl_discard: InstrValid rose %0d times, want 0", bad);
        end
        n_checks++;
        if (bus.IMemReq !== 1'b1 || bus.IMemAddr !== 32'h40) begin
            n_fail++;
            $display("FAIL fl_newpc: req=%b addr=%h want 1 40", bus.IMemReq, bus.IMemAddr);
        end
        bus.IMemAck  = 1'b1;
        bus.IMemData = 32'h0000_1234;
        @(negedge Clk);
        bus.IMemAck    = 1'b0;
        bus.InstrReady = 1'b1;
        n_checks++;
        if (bus.InstrValid !== 1'b1 || bus.Instr !== 32'h1234 || bus.InstrPC !== 32'h40) begin
            n_fail++;
            $display("FAIL fl_refetch: valid=%b instr=%h ipc=%h want 1 1234 40",
                     bus.InstrValid, bus.Instr, bus.InstrPC);
        end
        bus.PC = 32'h6;
        @(negedge Clk);
        bus.InstrReady = 1'b0;
    endtask

    task automatic test_misaligned();
        @(negedge Clk);
        n_checks++;
        if (bus.IMemReq !== 1'b0 || bus.InstrValid !== 1'b1 || bus.FetchErr !== 1'b1
            || bus.Instr !== 32'h0 || bus.InstrPC !== 32'h6) begin
            n_fail++;
            $display("FAIL mis_entry: req=%b valid=%b err=%b instr=%h ipc=%h want 0 1 1 0 6",
                     bus.IMemReq, bus.InstrValid, bus.FetchErr, bus.Instr, bus.InstrPC);
        end
        // Flush takes priority over a stalled FULL.
        bus.Flush = 1'b1;
        bus.PC    = 32'h30;
        @(negedge Clk);
        n_checks++;
        if (bus.InstrValid !== 1'b0 || bus.IMemReq !== 1'b0) begin
            n_fail++;
            $display("FAIL mis_flush: valid=%b req=%b want 0 0", bus.InstrValid, bus.IMemReq);
        end
        bus.Flush = 1'b0;
    endtask

    task automatic test_reset_in_wait();
        int bad = 0;
        @(negedge Clk);
        n_checks++;
        if (bus.IMemReq !== 1'b1 || bus.IMemAddr !== 32'h30) begin
            n_fail++;
            $display("FAIL rw_issue: req=%b addr=%h want 1 30", bus.IMemReq, bus.IMemAddr);
        end
        #2 Reset = 1'b0;
        #1;
        n_checks++;
        if (bus.IMemReq !== 1'b0 || bus.IMemAddr !== 32'h0 || bus.InstrValid !== 1'b0
            || bus.Instr !== 32'h0 || bus.InstrPC !== 32'h0 || bus.FetchErr !== 1'b0) begin
            n_fail++;
            $display("FAIL rw_async: req=%b addr=%h valid=%b instr=%h ipc=%h err=%b want all 0",
                     bus.IMemReq, bus.IMemAddr, bus.InstrValid, bus.Instr, bus.InstrPC,
                     bus.FetchErr);
        end
        @(negedge Clk);
        Reset     = 1'b1;
        bus.Flush = 1'b1;
        @(negedge Clk);
        bus.IMemAck  = 1'b1;
        bus.IMemData = 32'hCAFE_F00D;
        for (int i = 0; i < 3; i++) begin
            @(negedge Clk);
            if (bus.InstrValid !== 1'b0 || bus.IMemReq !== 1'b0) bad++;
        end
        n_checks++;
        if (bad != 0) begin
            n_fail++; $display("FAIL rw_late_ack: %0d cycles with activity, want 0", bad);
        end
        bus.IMemAck = 1'b0;
        bus.Flush   = 1'b0;
    endtask

    initial begin
        test_reset();
        test_zero_wait();
        test_wait4();
        test_stall();
        test_flush();
        test_misaligned();
        test_reset_in_wait();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
